ps2_key_event_rx: RTL and testbench

//  Parametrised PS/2 keyboard receiver for the npc top level; successor to the single-byte receiver.

---
 rtl/ps2_key_event_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx
//   PS/2 keyboard receiver. ps2_clk and ps2_data are oversampled through
//   synchronisers, and 11-bit frames are deframed with start, stop and odd
//   parity checks. E0/F0 prefix bytes fold into {ext,brk,code} key events,
//   which are queued in a first-word-fall-through FIFO.
//
// Ports
//   clk, rst                 system clock; async active-low reset
//   ps2_clk, ps2_data        asynchronous PS/2 bus, idle high
//   raw_mode                 1: every valid byte is pushed as-is with ext=brk=0
//   evt_ready                consumer accepts the head event
//   evt_valid                FIFO non-empty; evt_code/evt_ext/evt_brk show the head
//   evt_code, evt_ext,
//   evt_brk                  head event (0 while evt_valid=0)
//   fifo_count               occupied FIFO entries
//   clr_flags                clears overflow
//   overflow                 sticky: an event was dropped on a full FIFO
//   frame_err                1-cycle pulse on bad start/stop/parity or timeout
//   dbg_state                frame FSM state (0 IDLE, 1 RX, 2 CHECK)
//
// Handshake: the head event transfers on every clk edge where
//   evt_valid & evt_ready. While evt_valid=1 and evt_ready=0 the evt_*
//   outputs hold. A pushed event becomes visible the cycle after its push.
module ps2_key_event_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          raw_mode,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          clr_flags,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Synchronisers reset to 1 so reset never looks like a clock fall.
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  state_t          r_state;
  state_t          w_state_next;
  logic [10:0]     r_shift;
  logic [3:0]      r_bitcnt;
  logic [TW-1:0]   r_timer;
  logic            w_shift_en;
  logic            w_timer_inc;
  logic            w_timeout;

  logic            r_ext_pend;
  logic            r_brk_pend;
  logic            r_frame_err;
  logic            w_in_check;
  logic            w_frame_ok;
  logic [7:0]      w_byte;
  logic            w_is_prefix;
  logic            w_push;
  logic [9:0]      w_push_data;

  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Frame FSM: next state and datapath enables.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_timer_inc  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_shift_en   = 1'b1;
          w_state_next = ST_RX;
        end
      end
      ST_RX: begin
        if (w_fall) begin
          w_shift_en = 1'b1;
          // bitcnt already holds 10 captured bits: this fall is the stop bit
          if (r_bitcnt == 4'd10) w_state_next = ST_CHECK;
        end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ST_CHECK: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Frame layout after 11 LSB-first shifts: [0] start, [8:1] data,
  // [9] parity, [10] stop.
  assign w_in_check  = (r_state == ST_CHECK);
  assign w_byte      = r_shift[8:1];
  assign w_frame_ok  = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
  assign w_is_prefix = (w_byte == 8'hE0) || (w_byte == 8'hF0);
  assign w_push      = w_in_check & w_frame_ok & (raw_mode | ~w_is_prefix);
  assign w_push_data = raw_mode ? {2'b00, w_byte} : {r_ext_pend, r_brk_pend, w_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_timer     <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= w_timeout | (w_in_check & ~w_frame_ok);
      if (w_shift_en) begin
        r_shift  <= {w_data_s, r_shift[10:1]};
        r_bitcnt <= (r_state == ST_IDLE) ? 4'd1 : r_bitcnt + 4'd1;
        r_timer  <= '0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + TW'(1);
      end
      // Invalid frames leave pending prefixes untouched.
      if (raw_mode) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_in_check && w_frame_ok) begin
        if (w_byte == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

  // Event FIFO. A pop frees the slot a same-cycle push needs when full.
  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) & evt_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
    end
  end

  // Head is forced to 0 while empty so uninitialised storage never shows.
  assign evt_valid = (r_count != '0);
  assign {evt_ext, evt_brk, evt_code} = evt_valid ? r_mem[r_rd_ptr] : 10'd0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx
//   Directed bench for ps2_key_event_rx: single frames, prefix folding,
//   raw mode, parity error, FIFO fill/overflow/clear, push-with-pop on a
//   full FIFO, timeout abort and mid-frame reset.
module tb_ps2_key_event_rx;

  localparam int DEPTH      = 8;
  localparam int TB_TIMEOUT = 200;
  localparam int HALF       = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       raw_mode = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_flags = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       frame_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_rx #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TB_TIMEOUT),
    .SYNC_STAGES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .raw_mode  (raw_mode),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .fifo_count(fifo_count),
    .clr_flags (clr_flags),
    .overflow  (overflow),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && frame_err) ferr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle(input int n);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; ps2_clk ends high.
  task automatic frame_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = build_frame(b, bad_par);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  // Pops the head and compares it with the oldest expected event.
  task automatic pop_expect();
    logic [9:0] e;
    e = exp_q.pop_front();
    check_eq("head_valid", {31'd0, evt_valid}, 32'd1);
    check_eq("head_event", {22'd0, evt_ext, evt_brk, evt_code}, {22'd0, e});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  // Full frame; returns on the negedge inside the CHECK cycle (ps2_clk low),
  // optionally popping the head in that same cycle.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_at_check);
    logic [10:0] f;
    logic        seen;
    f = build_frame(b, bad_par);
    frame_bits(b, bad_par, 10);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) seen = 1'b1;
    end
    check_eq("reach_check", {31'd0, seen}, 32'd1);
    if (pop_at_check) pop_expect();
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_expect();
    check_eq(tag, {28'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    int ferr0;
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rst_count", {28'd0, fifo_count}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    bus_idle(5);

    // 1: single frame 0x1C with ready=1
    evt_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("t1_valid_in_check", {31'd0, evt_valid}, 32'd0);
    @(negedge clk);
    check_eq("t1_valid_next", {31'd0, evt_valid}, 32'd1);
    check_eq("t1_event", {22'd0, evt_ext, evt_brk, evt_code}, 32'h01C);
    @(negedge clk);
    check_eq("t1_popped", {31'd0, evt_valid}, 32'd0);
    evt_ready = 1'b0;
    bus_idle(5);
    check_eq("t1_no_ferr", ferr_cnt, 32'd0);

    // 2: prefix folding, then raw mode
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    bus_idle(5);
    check_eq("t2_count", {28'd0, fifo_count}, 32'd1);
    exp_q.push_back({2'b11, 8'h75});
    drain("t2_drained");
    raw_mode = 1'b1;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    bus_idle(5);
    check_eq("t2_raw_count", {28'd0, fifo_count}, 32'd3);
    exp_q.push_back({2'b00, 8'hE0});
    exp_q.push_back({2'b00, 8'hF0});
    exp_q.push_back({2'b00, 8'h75});
    drain("t2_raw_drained");
    raw_mode = 1'b0;

    // 3: bad parity, then a clean code
    ferr0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    bus_idle(5);
    check_eq("t3_ferr_pulse", ferr_cnt - ferr0, 32'd1);
    check_eq("t3_no_event", {28'd0, fifo_count}, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    bus_idle(5);
    exp_q.push_back({2'b00, 8'h1C});
    drain("t3_drained");

    // 4: fill past capacity with ready=0
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
      if (i < DEPTH) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
    end
    bus_idle(5);
    check_eq("t4_count_full", {28'd0, fifo_count}, 32'd8);
    check_eq("t4_overflow", {31'd0, overflow}, 32'd1);

    // 5: clear overflow, then push into the full FIFO while popping
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check_eq("t5_ovf_clear", {31'd0, overflow}, 32'd0);
    send_frame(8'h20, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 8'h20});
    bus_idle(5);
    check_eq("t5_count_kept", {28'd0, fifo_count}, 32'd8);
    check_eq("t5_no_drop", {31'd0, overflow}, 32'd0);
    drain("t5_drained");

    // 6: timeout abort after 5 bits
    ferr0 = ferr_cnt;
    frame_bits(8'h5A, 1'b0, 5);
    check_eq("t6_in_rx", {30'd0, dbg_state}, 32'd1);
    bus_idle(TB_TIMEOUT + 20);
    check_eq("t6_timeout_ferr", ferr_cnt - ferr0, 32'd1);
    check_eq("t6_idle", {30'd0, dbg_state}, 32'd0);
    check_eq("t6_no_event", {28'd0, fifo_count}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    bus_idle(5);
    exp_q.push_back({2'b00, 8'h5A});
    drain("t6_next_ok");

    // reset mid-frame with an event queued
    send_frame(8'h44, 1'b0, 1'b0);
    frame_bits(8'h55, 1'b0, 5);
    rst = 1'b0;
    #1;
    check_eq("rstm_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rstm_count", {28'd0, fifo_count}, 32'd0);
    check_eq("rstm_event", {22'd0, evt_ext, evt_brk, evt_code}, 32'd0);
    check_eq("rstm_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus_idle(5);
    send_frame(8'h1C, 1'b0, 1'b0);
    bus_idle(5);
    check_eq("rstm_after_count", {28'd0, fifo_count}, 32'd1);
    exp_q.push_back({2'b00, 8'h1C});
    drain("rstm_drained");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
